stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Sequencing controller for the stopwatch counter chain. Turns debounced start/stop, reset and lap buttons into the run/hold, clear and tick controls that the seconds/minutes counters consume. Generates the stopwatch tick with a prescaler, so the cascaded counters see a single-cycle enable strobe per time unit. Sits between the button front-end and the first counter stage.

## Interface

- DIV, 500_000: prescaler period in clk cycles per tick, ≥2.
- PW, 20: prescaler width; must satisfy 2^PW ≥ DIV.
- CLR_CYC, 2: number of cycles o_reset is held high per clear, ≥1.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- i_start_stop_btn  in  1  start/stop button, active-high level, debounced and synchronous to clk.
- i_reset_btn  in  1  clear button, same conditioning.
- i_lap_btn  in  1  lap button, same conditioning.
- o_Sw_Clk  out  1  tick strobe, one cycle high per DIV cycles while running.
- o_Start_Stop  out  1  1 = counters run, 0 = counters hold.
- o_reset  out  1  counter clear, high for CLR_CYC cycles per clear.
- o_lap  out  1  display freeze flag; counters keep running.
- o_state  out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 CLEAR.

## Operation

**Press detection**
- Each button has a registered previous value btn_q.
- press = btn & ~btn_q, evaluated every cycle.
- All btn_q registers reset to 1, so a button held through reset is not seen as a press.

**FSM**
- Priority within any state: reset press > start press > lap press.
- IDLE: reset press → CLEAR; start press → RUN; lap ignored.
- RUN: reset press → CLEAR; start press → PAUSE.
- PAUSE: reset press → CLEAR; start press → RUN.
- CLEAR: all presses ignored; after CLR_CYC cycles → IDLE.

**Output decode**
- o_Start_Stop = 1 only in RUN.
- o_reset = 1 only in CLEAR.
- o_state mirrors the state register.

**Prescaler (PW bits)**
- Forced to 0 in IDLE and CLEAR.
- In RUN: counts 0..DIV-1, then wraps to 0.
- In PAUSE: holds its value, so resume keeps tick phase.

**Tick**
- o_Sw_Clk is registered.
- It is high in the cycle after a RUN cycle in which the prescaler equals DIV-1.
- A start press on that same cycle still produces the tick; the prescaler wraps to 0, then holds in PAUSE.

**Lap**
- A lap press in RUN or PAUSE toggles o_lap.
- o_lap is forced to 0 on entry to CLEAR.

**Clear counter**
- Loaded to 0 on entry to CLEAR.
- Exits to IDLE when it reaches CLR_CYC-1.

## Timing

- Reset (rst low at an edge): state IDLE, prescaler 0, clear counter 0.
  - o_Sw_Clk=0, o_Start_Stop=0, o_reset=0, o_lap=0, o_state=00, from the next cycle.
- Reset applied mid-RUN or mid-CLEAR aborts immediately; no residual tick or clear pulse follows.
- Press latency: button rising edge sampled at cycle t → state and decoded outputs change at t+1.
- Tick timing, with RUN entered at cycle t (prescaler 0):
  - prescaler reaches DIV-1 at t+DIV-1;
  - o_Sw_Clk is high at t+DIV, then every DIV cycles.
- Tick count: exactly one o_Sw_Clk per DIV RUN cycles; never two consecutive high cycles, since DIV ≥ 2.
- Clear pulse: CLEAR entered at t → o_reset high for t..t+CLR_CYC-1; o_state=00 at t+CLR_CYC.
- A button held high produces exactly one press; it must go low for one or more cycles before it can press again.
- Simultaneous reset + start press in RUN → CLEAR; start is dropped.
- Pause preserves phase: PAUSE at prescaler value p, later resumed → first tick arrives DIV-p cycles after RUN re-entry.

## Test plan

Run with DIV=4, CLR_CYC=2.

1. **Reset values:** hold rst=0 for 3 cycles with all buttons high, then release, buttons still high → all outputs 0, o_state=00; no transition until a button falls and rises again.
2. **Start and tick:** start press at cycle t → o_Start_Stop=1 and o_state=01 at t+1; o_Sw_Clk high at t+5, t+9, t+13, one cycle each.
3. **Pause/resume phase:** run 6 cycles past RUN entry (prescaler=2), press start → PAUSE, no ticks for 10 cycles; press start again → first tick 2 cycles after RUN re-entry.
4. **Clear priority:** in RUN, assert reset and start presses on the same cycle → o_state=11; o_reset high exactly 2 cycles; then o_state=00, o_lap=0, o_Start_Stop=0.
5. **Lap:** in RUN, press lap → o_lap=1 while ticks continue; press lap again → o_lap=0; lap press in IDLE → o_lap stays 0.
6. **Reset mid-operation:** assert rst=0 during the cycle the prescaler equals 3 in RUN → no tick in the following cycle; all outputs 0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch sequencing controller with tick prescaler
//
// Turns debounced start/stop, clear and lap buttons into run/hold, clear and
// tick controls for the cascaded seconds/minutes counters.
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous reset, active-low
//   i_start_stop_btn start/stop button level (debounced, clk-synchronous)
//   i_reset_btn      clear button level
//   i_lap_btn        lap button level
//   o_Sw_Clk         one-cycle tick strobe every DIV running cycles
//   o_Start_Stop     1 = counters run, 0 = counters hold
//   o_reset          counter clear, high CLR_CYC cycles per clear
//   o_lap            display freeze flag
//   o_state          00 IDLE, 01 RUN, 10 PAUSE, 11 CLEAR

module stopwatch_ctrl #(
  parameter int DIV     = 500_000,
  parameter int PW      = 20,
  parameter int CLR_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start_stop_btn,
  input  logic       i_reset_btn,
  input  logic       i_lap_btn,
  output logic       o_Sw_Clk,
  output logic       o_Start_Stop,
  output logic       o_reset,
  output logic       o_lap,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_CLEAR = 2'b11
  } state_t;

  localparam int            CW         = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYC - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic          tick_q, tick_d;
  logic          run_q, run_d;
  logic          clr_q, clr_d;
  logic          lap_q, lap_d;
  logic          start_btn_q, reset_btn_q, lap_btn_q;
  logic          start_press, reset_press, lap_press;

  always_comb begin
    start_press = i_start_stop_btn & ~start_btn_q;
    reset_press = i_reset_btn & ~reset_btn_q;
    lap_press   = i_lap_btn & ~lap_btn_q;

    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    lap_d     = lap_q;

    // Only the highest-priority press in a cycle has any effect.
    case (state_q)
      S_IDLE: begin
        if (reset_press) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
          lap_d     = 1'b0;
        end else if (start_press) begin
          state_d = S_RUN;
        end
      end
      S_RUN, S_PAUSE: begin
        if (reset_press) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
          lap_d     = 1'b0;
        end else if (start_press) begin
          state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
        end else if (lap_press) begin
          lap_d = ~lap_q;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Prescaler follows the current state so a pause press on the wrap
    // cycle still wraps, and PAUSE keeps the phase for the next resume.
    case (state_q)
      S_RUN:   presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
      S_PAUSE: presc_d = presc_q;
      default: presc_d = '0;
    endcase

    tick_d = (state_q == S_RUN) && (presc_q == PRESC_LAST);
    run_d  = (state_d == S_RUN);
    clr_d  = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      clr_cnt_q   <= '0;
      tick_q      <= 1'b0;
      run_q       <= 1'b0;
      clr_q       <= 1'b0;
      lap_q       <= 1'b0;
      // Buttons held through reset must not register as presses.
      start_btn_q <= 1'b1;
      reset_btn_q <= 1'b1;
      lap_btn_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      clr_cnt_q   <= clr_cnt_d;
      tick_q      <= tick_d;
      run_q       <= run_d;
      clr_q       <= clr_d;
      lap_q       <= lap_d;
      start_btn_q <= i_start_stop_btn;
      reset_btn_q <= i_reset_btn;
      lap_btn_q   <= i_lap_btn;
    end
  end

  assign o_Sw_Clk     = tick_q;
  assign o_Start_Stop = run_q;
  assign o_reset      = clr_q;
  assign o_lap        = lap_q;
  assign o_state      = state_q;

endmodule
